// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the LED sequencer:
//   - LED_W      : width of the one-hot position / LED bus
//   - DIR_RIGHT  : command direction, rotate toward bit 0 (bit 0 wraps to MSB)
//   - DIR_LEFT   : command direction, rotate toward MSB (MSB wraps to bit 0)
//   - state_t    : sequencer FSM state encoding
//   - rotate_pos : one-step rotation of a one-hot position
// -----------------------------------------------------------------------------
package led_seq_pkg;

    localparam int LED_W = 4;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    // Rotation preserves the population count, so a one-hot input always
    // yields a one-hot output.
    function automatic logic [LED_W-1:0] rotate_pos(
        input logic [LED_W-1:0] p,
        input logic             dir
    );
        if (dir == DIR_LEFT) begin
            rotate_pos = {p[LED_W-2:0], p[LED_W-1]};
        end else begin
            rotate_pos = {p[0], p[LED_W-1:1]};
        end
    endfunction

endpackage : led_seq_pkg

// File: rtl/cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous 1-bit wide FIFO holding queued step directions.
//
// Parameters:
//   DEPTH   : number of entries, power of two, at least 2
// Ports:
//   clk     : clock, all state updates on the rising edge
//   rst     : asynchronous active-high reset, empties the FIFO
//   wr_en   : push request (ignored while full)
//   wr_data : direction bit to push
//   rd_en   : pop request (ignored while empty)
//   rd_data : head entry, valid whenever empty is low
//   full    : all DEPTH entries occupied
//   empty   : no entries occupied
// -----------------------------------------------------------------------------
module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  logic wr_data,
    input  logic rd_en,
    output logic rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [DEPTH-1:0] r_mem;

    logic w_push;
    logic w_pop;

    assign full    = (r_count == FULL_CNT);
    assign empty   = (r_count == '0);
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;

    // The head is read combinationally: the sequencer consumes an entry on
    // the same edge it pops it, so a registered read would add a cycle of
    // latency between acceptance and the position update.
    assign rd_data = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH by
    // natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Push and pop together leave the occupancy unchanged.
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : cmd_fifo

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
// Steps a one-hot lit position left or right on queued commands, holding the
// position for at least DWELL cycles after each step, and drives the LEDs
// through a 4-bit PWM brightness gate.
//
// Parameters:
//   DWELL      : minimum cycles the position is held after a step (>= 1)
//   DEPTH      : command FIFO entries, power of two
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   cmd_valid  : step command offered
//   cmd_dir    : step direction (DIR_RIGHT / DIR_LEFT)
//   cmd_ready  : command accepted when cmd_valid && cmd_ready at an edge
//   brightness : PWM duty level, 0 = dark, 15 = always on
//   led        : registered, PWM-gated one-hot position
//   busy       : commands queued or a dwell in progress
// -----------------------------------------------------------------------------
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter logic [15:0] DWELL = 16'd50000,
    parameter int          DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic             cmd_dir,
    output logic             cmd_ready,
    input  logic [3:0]       brightness,
    output logic [LED_W-1:0] led,
    output logic             busy
);

    // Counter reload value; the extra IDLE cycle makes consecutive steps
    // DWELL+1 cycles apart.
    localparam logic [15:0] DWELL_LOAD = (DWELL == 16'd0) ? 16'd0 : DWELL - 16'd1;

    // FIFO interface
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_fifo_dout;
    logic w_push;
    logic w_pop;

    // FSM and datapath state
    state_t           r_state;
    state_t           w_state_next;
    logic [LED_W-1:0] r_pos;
    logic [LED_W-1:0] w_pos_next;
    logic [15:0]      r_dwell_cnt;
    logic [15:0]      w_dwell_next;

    // PWM
    logic [3:0]       r_pwm_cnt;
    logic             w_gate;
    logic [LED_W-1:0] r_led;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    // Ready depends on occupancy only, so a full FIFO refuses a push even
    // in a cycle where the FSM is about to pop.
    assign cmd_ready = !w_fifo_full;
    assign w_push    = cmd_valid && !w_fifo_full;

    cmd_fifo #(
        .DEPTH   (DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (cmd_dir),
        .rd_en   (w_pop),
        .rd_data (w_fifo_dout),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Step FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pos       <= LED_W'(1);
            r_dwell_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pos       <= w_pos_next;
            r_dwell_cnt <= w_dwell_next;
        end
    end

    // ------------------------------------------------------------------
    // Step FSM: next state, pop, position and dwell counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pos_next   = r_pos;
        w_dwell_next = r_dwell_cnt;
        w_pop        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Pop, rotate and start the dwell on one edge; only entries
                // already in the FIFO are eligible (no bypass from cmd_dir).
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_pos_next   = rotate_pos(r_pos, w_fifo_dout);
                    w_dwell_next = DWELL_LOAD;
                    w_state_next = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (r_dwell_cnt == 16'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_dwell_next = r_dwell_cnt - 16'd1;
                end
            end
        endcase
    end

    assign busy = !w_fifo_empty || (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // PWM brightness gate
    // ------------------------------------------------------------------
    // Free-running; a brightness change is seen at the next comparison
    // without restarting the period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    // Level 15 is forced fully on; the compare alone would leave a one
    // cycle gap at count 15.
    assign w_gate = (r_pwm_cnt < brightness) || (brightness == 4'hF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= r_pos & {LED_W{w_gate}};
        end
    end

    assign led = r_led;

endmodule : led_sequencer

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
// Randomised and directed stimulus against a queue/arithmetic reference model.
// The model pushes one expected {led, cmd_ready, busy} entry per clock edge
// into a scoreboard; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_led_sequencer;

    localparam logic [15:0] DWELL = 16'd4;
    localparam int          DEPTH = 4;
    localparam int          DW    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir = 1'b0;
    logic       cmd_ready;
    logic [3:0] brightness = 4'hF;
    logic [3:0] led;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    led_sequencer #(
        .DWELL      (DWELL),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_dir    (cmd_dir),
        .cmd_ready  (cmd_ready),
        .brightness (brightness),
        .led        (led),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // Position is an index 0..3 (lit bit = 1 << index). A step may happen
    // at edge t when commands are queued and t is at least DWELL+1 edges
    // after the previous step. The PWM count equals edges since reset mod 16.
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] led;
        logic       ready;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    int   m_cyc;
    int   m_last;
    int   m_idx;
    bit   m_q[$];

    initial begin : model
        exp_t e;
        int   pwm;
        bit   acc;
        bit   stp;
        bit   d;
        bit   gate;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cyc  = 0;
                m_last = -100;
                m_idx  = 0;
                m_q.delete();
                sb.delete();
                e.led   = 4'b0000;
                e.ready = 1'b1;
                e.busy  = 1'b0;
                sb.push_back(e);
            end else begin
                acc  = cmd_valid && (m_q.size() < DEPTH);
                stp  = (m_q.size() > 0) && (m_cyc >= m_last + DW + 1);
                pwm  = m_cyc % 16;
                gate = (pwm < int'(brightness)) || (brightness == 4'd15);
                e.led = gate ? 4'(1 << m_idx) : 4'b0000;
                if (stp) begin
                    d = m_q.pop_front();
                    m_idx  = d ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
                    m_last = m_cyc;
                end
                if (acc) begin
                    m_q.push_back(cmd_dir);
                end
                e.ready = (m_q.size() < DEPTH);
                e.busy  = (m_q.size() > 0) || ((m_cyc - m_last) < DW);
                sb.push_back(e);
                m_cyc++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = sb.pop_front();
                chk("led",       led,               e.led);
                chk("cmd_ready", {3'b000, cmd_ready}, {3'b000, e.ready});
                chk("busy",      {3'b000, busy},      {3'b000, e.busy});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit dir);
        bit ok;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        for (int i = 0; i < 200; i++) begin
            ok = cmd_ready;
            tick(1);
            if (ok) begin
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: got no acceptance expected acceptance within 200 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy) return;
            tick(1);
        end
        n_vec++;
        n_err++;
        $display("FAIL idle_timeout: got busy=1 expected busy=0 within 300 cycles");
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2000000");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        tick(3);
        rst = 1'b0;
        tick(2);

        // Single right step at full brightness
        send(1'b0);
        wait_idle();
        tick(3);

        // Back-to-back burst, FIFO fills during the dwell
        for (int i = 0; i < 5; i++) send(i[0]);
        wait_idle();

        // Left x4 wraps, then right x1
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            send(1'b1);
            wait_idle();
        end
        send(1'b0);
        wait_idle();

        // PWM levels
        brightness = 4'd4;
        tick(40);
        brightness = 4'd0;
        send(1'b1);
        send(1'b1);
        tick(20);
        brightness = 4'd15;
        tick(20);

        // Reset mid-dwell with three entries queued
        for (int i = 0; i < 4; i++) send(1'b1);
        tick(1);
        rst = 1'b1;
        #3;
        tick(1);
        rst = 1'b0;
        tick(30);

        // Full FIFO with a push offered while the FSM pops
        for (int i = 0; i < 6; i++) send(i[1]);
        wait_idle();

        // Random traffic, brightness changes and occasional resets
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_dir   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 19) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) begin
                cmd_valid = 1'b0;
                pulse_reset();
            end else begin
                tick(1);
            end
        end
        cmd_valid = 1'b0;
        wait_idle();
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_led_sequencer

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 16'd50000: minimum clk cycles the lit position is held after each step.
REQ-002 SHALL have parameter DEPTH, default 4: command FIFO entries, power of two.
REQ-003 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1: step command offered.
REQ-006 SHALL have port cmd_dir, input, 1: step direction; 0 = rotate right {p[0],p[3:1]}, 1 = rotate left {p[2:0],p[3]}.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-008 SHALL have port brightness, input, 4: PWM duty level.
REQ-009 SHALL have port led, output, 4: registered, PWM-gated one-hot position.
REQ-010 SHALL have port busy, output, 1: high while the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-011 SHALL hold position register pos, one-hot in 4 bits at all times.
REQ-012 SHALL drive cmd_ready = !fifo_full, combinationally from FIFO occupancy only, independent of cmd_valid.
REQ-013 SHALL write cmd_dir into the FIFO on acceptance; SHALL drop nothing while cmd_ready is high; SHALL not accept commands while full.
REQ-014 SHALL implement FSM states IDLE and DWELL.
REQ-015 In IDLE with FIFO non-empty, SHALL pop one entry, rotate pos per its direction, load dwell counter with DWELL-1, and enter DWELL, all on the same edge.
REQ-016 In IDLE with FIFO empty, SHALL remain in IDLE, pos unchanged.
REQ-017 In DWELL, SHALL decrement the counter each cycle and return to IDLE on the edge where the counter is 0.
REQ-018 Consecutive queued steps SHALL update pos exactly DWELL+1 cycles apart.
REQ-019 A command accepted at edge N into an empty FIFO with FSM in IDLE SHALL update pos at edge N+1 (no bypass path).
REQ-020 Simultaneous push and pop in one cycle SHALL leave occupancy unchanged and preserve FIFO order.
REQ-021 The FIFO pointers SHALL wrap modulo DEPTH; the occupancy count SHALL be log2(DEPTH)+1 bits wide.
REQ-022 SHALL run a free-running 4-bit PWM counter, wrapping from 15 to 0.
REQ-023 The PWM gate SHALL be (pwm_cnt < brightness) || (brightness == 4'hF).
REQ-024 SHALL register led <= pos & {4{gate}}, giving one cycle of latency from pos/pwm_cnt to led.
REQ-025 brightness = 0 SHALL keep led = 0 while pos still advances.
REQ-026 A brightness change SHALL take effect on the next PWM comparison, with no resynchronisation of the PWM counter.

Reset
REQ-027 Asserting rst SHALL, without a clock edge, set pos = 4'b0001, led = 4'b0000, FIFO empty, state = IDLE, dwell counter = 0, and pwm_cnt = 0.
REQ-028 Reset asserted mid-DWELL or with a non-empty FIFO SHALL discard all pending commands.
REQ-029 After reset, cmd_ready SHALL be 1 and busy SHALL be 0.

Structure
REQ-030 Package led_seq_pkg SHALL hold the FSM state typedef, the DIR_RIGHT = 1'b0 and DIR_LEFT = 1'b1 constants, and the LED width constant 4.
REQ-031 The FIFO SHALL be a sub-module named cmd_fifo (synchronous, 1-bit wide, DEPTH entries, full/empty flags), sharing clk/rst.

Verification (DWELL = 4, DEPTH = 4)
REQ-032 Reset, brightness = 15, one right command -> pos 0001→1000 one edge after acceptance; led = 1000 one edge after that; busy drops after 5 cycles.
REQ-033 Five back-to-back commands with FSM stalled in DWELL -> cmd_ready goes low after four accepted; the fifth is held; all steps occur 5 cycles apart, in order.
REQ-034 Left ×4 from 0001 -> 0010, 0100, 1000, 0001 (wrap); right ×1 from 0001 -> 1000.
REQ-035 brightness = 4 -> led is on for 4 of every 16 cycles; brightness = 0 -> led stays 0; brightness = 15 -> led is constant.
REQ-036 Assert rst mid-DWELL with 3 entries queued -> pos = 0001, led = 0, busy = 0, cmd_ready = 1 immediately; no further steps occur.
REQ-037 Full FIFO, push offered while IDLE pops -> the push is refused that cycle (ready = 0) and accepted the next cycle; order is preserved.
